line_buffer3: RTL and testbench
===============================

Name: line_buffer3

Overview:
- Raster-to-column stage directly upstream of the 3x3 convolution kernel block.
- Accepts one pixel per valid cycle in raster order and stores the two previous image rows in on-chip line memories.
- Each accepted pixel produces one registered vertical triple (top/mid/bot rows of the same column) plus a shift strobe. These drive the kernel's pix_top/pix_mid/pix_bot/shift_en directly.
- Tracks column/row position, flags when the 3x3 window centre is fully inside the image, and pulses end-of-frame.

Parameters:
- PIXEL_WIDTH, 8: bits per pixel.
- IMG_WIDTH, 640: pixels per line; line memory depth; must be >= 3.
- IMG_HEIGHT, 480: lines per frame; must be >= 3.
- CW, $clog2(IMG_WIDTH): column counter width.
- RW, $clog2(IMG_HEIGHT): row counter width.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_pixel is valid this cycle; there is no backpressure.
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0).
- in_pixel  in  PIXEL_WIDTH  raster pixel.
- pix_top  out  PIXEL_WIDTH  pixel two rows above the current one, same column.
- pix_mid  out  PIXEL_WIDTH  pixel one row above, same column.
- pix_bot  out  PIXEL_WIDTH  current input pixel.
- shift_en  out  1  triple valid; one pulse per accepted pixel.
- window_valid  out  1  downstream kernel's window centre lies inside the image (see Behaviour).
- eof  out  1  pulse with the triple of the last pixel of a frame.
- col  out  CW  column of the current pix_bot.
- row  out  RW  row of the current pix_bot.

Behaviour:
- Reset (async assert, sync release): pix_top/mid/bot=0, shift_en=0, window_valid=0, eof=0, col=0, row=0, internal counters=0. Line memories are not reset.
- Accept: in_valid=1. Let c = internal column counter and r = internal row counter.
  - Read mem_a[c] (row r-1) and mem_b[c] (row r-2).
  - Write mem_b[c] <= mem_a[c] and mem_a[c] <= in_pixel.
  - Read-before-write on the same address within the cycle.
- Latency: exactly 1 cycle. On the cycle after an accept: shift_en=1, pix_bot=in_pixel, pix_mid=old mem_a[c], pix_top=old mem_b[c], col=c, row=r.
- No accept: shift_en=0 and the data outputs hold their values. Gaps of any length between valid pixels are legal.
- Counters advance on accept:
  - c increments; at c==IMG_WIDTH-1, c wraps to 0 and r increments.
  - At c==IMG_WIDTH-1 and r==IMG_HEIGHT-1, both wrap to 0 and eof is registered high with that triple.
- in_sof with in_valid forces the pixel to (0,0) regardless of counter state. Counters continue from (0,1). This is mid-frame resync; the memories are not flushed.
- in_sof without in_valid is ignored.
- window_valid, registered with the triple, equals (r>=2) && (c>=2). The kernel's centre tap is (r-1, c-1), so all 9 taps are in-image exactly then. window_valid=0 whenever shift_en=0.
- eof and window_valid are single-cycle pulses aligned with shift_en.
- Reset mid-frame discards all position state; the next accepted pixel is (0,0) whether or not in_sof is asserted.

Optional Feature:
- Macro: LINE_BUFFER3_BORDER_ZERO_EN.
- Defined: on rows 0 and 1 the stale memory contents are masked.
  - Row 0: pix_top=0 and pix_mid=0.
  - Row 1: pix_top=0.
  - This also yields deterministic outputs after reset.
- Undefined: raw memory contents are output (previous-frame data or X after reset). Consumers must gate on window_valid.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, PIXEL_WIDTH=8):
- Reset, then 12 consecutive pixels 1..12 with in_sof on the first -> 12 shift_en pulses, each 1 cycle after its input.
  - Pixel 9 triple: top=1, mid=5, bot=9, col=0, row=2, window_valid=0.
  - Pixel 11 triple: top=3, mid=7, bot=11, window_valid=1.
  - Pixel 12: window_valid=1, eof=1.
- Same 12-pixel stream with in_valid low every other cycle -> identical triple sequence; outputs hold during gaps; shift_en low during gaps.
- Second frame 101..112 back to back after the first -> pixel 101 triple has top=5, mid=9 (previous-frame data, macro undefined).
  - With LINE_BUFFER3_BORDER_ZERO_EN: top=0, mid=0 for 101..104, and top=0 for 105..108.
- in_sof asserted on the 6th pixel of a frame -> that triple reports col=0, row=0, and the following pixel reports col=1, row=0.
- rst_n pulsed low asynchronously mid-row, between clock edges -> all outputs 0 immediately. The next accepted pixel without in_sof reports col=0, row=0.
- in_sof with in_valid=0 -> no counter change and no shift_en.

Source files
------------

// File: rtl/line_buffer3.sv
// Raster-to-column line buffer feeding a 3x3 kernel: emits a registered vertical pixel triple per accepted pixel.
// Optional macro LINE_BUFFER3_BORDER_ZERO_EN masks stale line-memory data on rows 0 and 1.
module line_buffer3 #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480,
  parameter int unsigned CW          = $clog2(IMG_WIDTH),
  parameter int unsigned RW          = $clog2(IMG_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic [PIXEL_WIDTH-1:0] pix_top,
  output logic [PIXEL_WIDTH-1:0] pix_mid,
  output logic [PIXEL_WIDTH-1:0] pix_bot,
  output logic                   shift_en,
  output logic                   window_valid,
  output logic                   eof,
  output logic [CW-1:0]          col,
  output logic [RW-1:0]          row
);

  logic [PIXEL_WIDTH-1:0] mem_a [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] mem_b [IMG_WIDTH];

  logic [CW-1:0]          c_q, c_cur_c, c_nxt_c;
  logic [RW-1:0]          r_q, r_cur_c, r_nxt_c;
  logic                   last_col_c, last_row_c;
  logic [PIXEL_WIDTH-1:0] rd_a_c, rd_b_c, top_c, mid_c;

  // Position of the pixel being accepted; start-of-frame forces (0,0).
  always_comb begin
    c_cur_c    = in_sof ? '0 : c_q;
    r_cur_c    = in_sof ? '0 : r_q;
    last_col_c = (c_cur_c == CW'(IMG_WIDTH - 1));
    last_row_c = (r_cur_c == RW'(IMG_HEIGHT - 1));
    c_nxt_c    = last_col_c ? '0 : c_cur_c + CW'(1);
    r_nxt_c    = r_cur_c;
    if (last_col_c) begin
      r_nxt_c = last_row_c ? '0 : r_cur_c + RW'(1);
    end
  end

  always_comb begin
    rd_a_c = mem_a[c_cur_c];
    rd_b_c = mem_b[c_cur_c];
`ifdef LINE_BUFFER3_BORDER_ZERO_EN
    mid_c  = (r_cur_c == RW'(0)) ? '0 : rd_a_c;
    top_c  = (r_cur_c <= RW'(1)) ? '0 : rd_b_c;
`else
    mid_c  = rd_a_c;
    top_c  = rd_b_c;
`endif
  end

  // Line memories: row r-1 shifts down into the r-2 slot as the new pixel lands.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_b[c_cur_c] <= mem_a[c_cur_c];
      mem_a[c_cur_c] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      r_q <= '0;
    end else if (in_valid) begin
      c_q <= c_nxt_c;
      r_q <= r_nxt_c;
    end
  end

  // Registered triple and position; data holds between accepts, strobes drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_top      <= '0;
      pix_mid      <= '0;
      pix_bot      <= '0;
      shift_en     <= 1'b0;
      window_valid <= 1'b0;
      eof          <= 1'b0;
      col          <= '0;
      row          <= '0;
    end else if (in_valid) begin
      pix_top      <= top_c;
      pix_mid      <= mid_c;
      pix_bot      <= in_pixel;
      shift_en     <= 1'b1;
      window_valid <= (r_cur_c >= RW'(2)) && (c_cur_c >= CW'(2));
      eof          <= last_col_c && last_row_c;
      col          <= c_cur_c;
      row          <= r_cur_c;
    end else begin
      shift_en     <= 1'b0;
      window_valid <= 1'b0;
      eof          <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buffer3.sv
// Self-checking bench for line_buffer3 (4x3 image): directed plan plus random stream against a column-history model.
module tb_line_buffer3;
  localparam int unsigned PW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic [PW-1:0] pix_top, pix_mid, pix_bot;
  logic          shift_en, window_valid, eof;
  logic [1:0]    col;
  logic [1:0]    row;

  line_buffer3 #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .pix_top(pix_top), .pix_mid(pix_mid), .pix_bot(pix_bot), .shift_en(shift_en),
    .window_valid(window_valid), .eof(eof), .col(col), .row(row)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: raster index within frame, and per-column history of written pixels.
  int idx = 0;
  int hist1 [W];
  int hist2 [W];
  int nwr [W];
  int e_top = 0, e_mid = 0, e_bot = 0, e_col = 0, e_row = 0;
  bit top_known = 1, mid_known = 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; checks outputs just after the next one.
  task automatic step(input bit v, input bit s, input int pix);
    int u, c, r;
    bit wv, ef;
    u = 0; c = 0; r = 0; wv = 0; ef = 0;
    in_valid = v; in_sof = s; in_pixel = PW'(pix);
    if (v) begin
      u = s ? 0 : idx;
      c = u % W;
      r = u / W;
      wv = (r >= 2) && (c >= 2);
      ef = (u == W * H - 1);
      e_bot = pix; e_col = c; e_row = r;
      mid_known = nwr[c] >= 1;
      top_known = nwr[c] >= 2;
      e_mid = hist1[c];
      e_top = hist2[c];
`ifdef LINE_BUFFER3_BORDER_ZERO_EN
      if (r == 0) begin e_mid = 0; mid_known = 1; end
      if (r <= 1) begin e_top = 0; top_known = 1; end
`endif
      hist2[c] = hist1[c];
      hist1[c] = pix;
      nwr[c]++;
      idx = (u + 1) % (W * H);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
    chk("shift_en", int'(shift_en), int'(v));
    chk("window_valid", int'(window_valid), int'(wv));
    chk("eof", int'(eof), int'(ef));
    chk("pix_bot", int'(pix_bot), e_bot);
    chk("col", int'(col), e_col);
    chk("row", int'(row), e_row);
    if (mid_known) chk("pix_mid", int'(pix_mid), e_mid);
    if (top_known) chk("pix_top", int'(pix_top), e_top);
  endtask

  task automatic check_reset_outputs();
    chk("rst_top", int'(pix_top), 0);
    chk("rst_mid", int'(pix_mid), 0);
    chk("rst_bot", int'(pix_bot), 0);
    chk("rst_shift_en", int'(shift_en), 0);
    chk("rst_window_valid", int'(window_valid), 0);
    chk("rst_eof", int'(eof), 0);
    chk("rst_col", int'(col), 0);
    chk("rst_row", int'(row), 0);
    idx = 0;
    e_top = 0; e_mid = 0; e_bot = 0; e_col = 0; e_row = 0;
    top_known = 1; mid_known = 1;
  endtask

  initial begin
    for (int i = 0; i < W; i++) begin hist1[i] = 0; hist2[i] = 0; nwr[i] = 0; end
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1 back to back
    for (int p = 1; p <= 12; p++) step(1'b1, p == 1, p);
    // Same stream with a gap after every pixel
    for (int p = 1; p <= 12; p++) begin
      step(1'b1, p == 1, p);
      step(1'b0, 1'b0, 0);
    end
    // Second frame immediately after the first
    for (int p = 101; p <= 112; p++) step(1'b1, 1'b0, p);
    // Mid-frame resync on the 6th pixel
    for (int p = 1; p <= 8; p++) step(1'b1, p == 1 || p == 6, 20 + p);

    // Asynchronous reset asserted mid-row between clock edges
    step(1'b1, 1'b1, 50);
    step(1'b1, 1'b0, 51);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 52);
    step(1'b1, 1'b0, 53);

    // Start-of-frame without valid is ignored
    step(1'b0, 1'b1, 99);
    step(1'b1, 1'b0, 54);

    // Randomized traffic with occasional resync
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, int'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
